// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    DONE    = 3'd3,
    ASSERT  = 3'd4
  } rst_seq_state_e;

  // Counter has to reach the larger of the hold time and the stagger.
  function automatic int cnt_width(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after STAGES clk edges.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign sync_rst_n = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer: sync, hold, staggered per-channel release, soft re-run.
// Optional RST_SEQ_CNT_EN adds a saturating soft-reset counter and last-released-channel index.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [2:0]        seq_state
`ifdef RST_SEQ_CNT_EN
  ,
  output logic [7:0]                       rst_count,
  output logic [idx_width(NUM_CH)-1:0]     last_rel_ch
`endif
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGGER);
  localparam int SW = $clog2(NUM_CH + 1);
`ifdef RST_SEQ_CNT_EN
  localparam int IW = idx_width(NUM_CH);
`endif

  logic              sync_rst_n;
  rst_seq_state_e    state;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     slot;
  logic [SW-1:0]     nxt_slot;
  logic [NUM_CH-1:0] mask_q;

  assign nxt_slot  = slot + 1'b1;
  assign seq_state = state;

  rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (reset),
    .sync_rst_n (sync_rst_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      cnt      <= '0;
      slot     <= '0;
      mask_q   <= '0;
      ch_rst_n <= '0;
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
`ifdef RST_SEQ_CNT_EN
      rst_count   <= '0;
      last_rel_ch <= '0;
`endif
    end else if (sw_rst_req && state != SYNC) begin
      // Soft request beats any count in progress, even mid-release.
      state    <= ASSERT;
      cnt      <= '0;
      slot     <= '0;
      ch_rst_n <= '0;
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
`ifdef RST_SEQ_CNT_EN
      if (rst_count != 8'hFF) rst_count <= rst_count + 1'b1;
`endif
    end else begin
      case (state)
        SYNC: begin
          if (sync_rst_n) state <= HOLD;
        end
        HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            state       <= RELEASE;
            cnt         <= '0;
            slot        <= '0;
            mask_q      <= ch_mask;
            ch_rst_n[0] <= ~ch_mask[0];
`ifdef RST_SEQ_CNT_EN
            if (!ch_mask[0]) last_rel_ch <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == CW'(STAGGER - 1)) begin
            cnt <= '0;
            if (slot == SW'(NUM_CH - 1)) begin
              state    <= DONE;
              slot     <= '0;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              slot <= nxt_slot;
              for (int i = 0; i < NUM_CH; i++) begin
                if (SW'(i) == nxt_slot && !mask_q[i]) begin
                  ch_rst_n[i] <= 1'b1;
`ifdef RST_SEQ_CNT_EN
                  last_rel_ch <= IW'(i);
`endif
                end
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        ASSERT: begin
          state <= HOLD;
          cnt   <= '0;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: an edge-count reference model predicts outputs per edge.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int N  = 4;
  localparam int H  = 16;
  localparam int ST = 4;
  localparam int S  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         sw_rst_req;
  logic [N-1:0] ch_mask;
  logic [N-1:0] ch_rst_n;
  logic         seq_busy;
  logic         seq_done;
  logic [2:0]   seq_state;
`ifdef RST_SEQ_CNT_EN
  logic [7:0]   rst_count;
  logic [1:0]   last_rel_ch;
`endif

  typedef struct {
    logic [N-1:0] ch;
    logic         busy;
    logic         done;
    logic [2:0]   st;
    logic [7:0]   cnt;
    logic [1:0]   last;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state: edges since reset release, edge HOLD was (re)entered.
  int k = 0;
  int h = 0;
  int rc = 0;
  int last = 0;
  logic [N-1:0] mask_lat = '0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_CH(N), .HOLD_CYCLES(H), .STAGGER(ST), .SYNC_STAGES(S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .ch_mask    (ch_mask),
    .ch_rst_n   (ch_rst_n),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .seq_state  (seq_state)
`ifdef RST_SEQ_CNT_EN
    ,
    .rst_count   (rst_count),
    .last_rel_ch (last_rel_ch)
`endif
  );

  task automatic model_reset();
    exp_t e;
    k = 0; rc = 0; last = 0; mask_lat = '0;
    e.ch = '0; e.busy = 1'b1; e.done = 1'b0; e.st = SYNC; e.cnt = '0; e.last = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic req, input logic [N-1:0] m);
    exp_t e;
    int d, slot;
    logic [N-1:0] rel;
    k++;
    e.ch = '0; e.busy = 1'b1; e.done = 1'b0; e.st = SYNC;
    if (k == S + 1) begin
      h = k;
      e.st = HOLD;
    end else if (k > S + 1) begin
      if (req) begin
        h = k + 1;
        if (rc < 255) rc++;
        e.st = ASSERT;
      end else begin
        d = k - h;
        if (d < H) begin
          e.st = HOLD;
        end else begin
          if (d == H) mask_lat = m;
          slot = (d - H) / ST;
          if (slot >= N) begin
            rel = '1;
            e.st = DONE; e.busy = 1'b0; e.done = 1'b1;
          end else begin
            rel = N'((2 << slot) - 1);
            e.st = RELEASE;
          end
          e.ch = rel & ~mask_lat;
          for (int j = 0; j < N; j++) if (e.ch[j]) last = j;
        end
      end
    end
    e.cnt  = 8'(rc);
    e.last = 2'(last);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic req, input logic [N-1:0] m, input bit hard);
    sw_rst_req = req;
    ch_mask    = m;
    @(posedge clk);
    if (hard) begin
      model_reset();
      #3 reset = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
    end else begin
      model_step(req, m);
      #1;
    end
  endtask

  task automatic run_to(input int edge_n, input logic [N-1:0] m);
    while (k < edge_n - 1) cycle(1'b0, m, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, expv, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ch_rst_n",  32'(ch_rst_n),  32'(e.ch));
        chk("seq_busy",  32'(seq_busy),  32'(e.busy));
        chk("seq_done",  32'(seq_done),  32'(e.done));
        chk("seq_state", 32'(seq_state), 32'(e.st));
`ifdef RST_SEQ_CNT_EN
        chk("rst_count",   32'(rst_count),   32'(e.cnt));
        chk("last_rel_ch", 32'(last_rel_ch), 32'(e.last));
`endif
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1; sw_rst_req = 1'b0; ch_mask = '0;
    #1 reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      model_reset();
    end
    @(negedge clk);
    #1 reset = 1'b1;

    // Plain power-up sequence, then masked channel 2 with a soft request in DONE.
    run_to(41, '0);
    cycle(1'b0, '0, 1'b1);
    run_to(50, 4'b0100);
    cycle(1'b1, 4'b0100, 1'b0);
    run_to(91, 4'b0100);

    // Async reset at edge 21, then a soft request mid-release at edge 25.
    cycle(1'b0, '0, 1'b1);
    run_to(21, '0);
    cycle(1'b0, '0, 1'b1);
    run_to(25, '0);
    cycle(1'b1, '0, 1'b0);
    run_to(k + 60, '0);

    // Held request: re-enters ASSERT each cycle, counter saturates.
    repeat (300) cycle(1'b1, '0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b0);

    // Random phase: sparse requests, random masks, rare async resets.
    repeat (3000) begin
      r = $urandom_range(0, 999);
      cycle(r >= 3 && r < 40, N'($urandom), r < 3);
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
